// File: rtl/slurm16_wb_pkg.sv
// Shared encodings for the SLURM16 writeback queue: request kinds, byte-lane
// selects and the register that receives the interrupt return address.
package slurm16_wb_pkg;

    typedef enum logic [1:0] {
        KIND_DIRECT       = 2'd0,
        KIND_LOAD_WORD    = 2'd1,
        KIND_LOAD_BYTE_ZX = 2'd2,
        KIND_LOAD_BYTE_SX = 2'd3
    } wb_kind_t;

    localparam logic [1:0] BYTE_SEL_UPPER = 2'b10;
    localparam logic [1:0] BYTE_SEL_LOWER = 2'b01;

    localparam int INTERRUPT_LINK_REGISTER = 126;

endpackage

// File: rtl/slurm16_cpu_wb_load_fifo.sv
// In-order queue of outstanding loads (dest, kind, byte_sel) with a per-entry
// destination match vector. SLURM16_WB_SCOREBOARD_EN adds a second match port.
module slurm16_cpu_wb_load_fifo
    import slurm16_wb_pkg::*;
#(
    parameter int REGISTER_BITS = 7,
    parameter int DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic [REGISTER_BITS-1:0]     push_dest,
    input  wb_kind_t                     push_kind,
    input  logic [1:0]                   push_byte_sel,
    input  logic                         pop,
    output logic [REGISTER_BITS-1:0]     head_dest,
    output wb_kind_t                     head_kind,
    output logic [1:0]                   head_byte_sel,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [REGISTER_BITS-1:0]     match_dest,
    output logic [DEPTH-1:0]             match_vec
`ifdef SLURM16_WB_SCOREBOARD_EN
    ,
    input  logic [REGISTER_BITS-1:0]     query_dest,
    output logic [DEPTH-1:0]             query_vec
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg;
    logic [DEPTH-1:0]         valid_reg;
    logic [REGISTER_BITS-1:0] dest_mem     [DEPTH];
    wb_kind_t                 kind_mem     [DEPTH];
    logic [1:0]               byte_sel_mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;

    assign head_dest     = dest_mem[rd_ptr_reg];
    assign head_kind     = kind_mem[rd_ptr_reg];
    assign head_byte_sel = byte_sel_mem[rd_ptr_reg];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            dest_mem[wr_ptr_reg]     <= push_dest;
            kind_mem[wr_ptr_reg]     <= push_kind;
            byte_sel_mem[wr_ptr_reg] <= push_byte_sel;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match_vec[gi] = valid_reg[gi] && (dest_mem[gi] == match_dest);
`ifdef SLURM16_WB_SCOREBOARD_EN
        assign query_vec[gi] = valid_reg[gi] && (dest_mem[gi] == query_dest);
`endif
    end

endmodule

// File: rtl/slurm16_cpu_writeback_queue.sv
// Single-port register writeback arbiter (IRQ link > load retire > direct) with
// an in-order pending-load queue. SLURM16_WB_SCOREBOARD_EN adds query_sel/query_pending.
module slurm16_cpu_writeback_queue
    import slurm16_wb_pkg::*;
#(
    parameter int REGISTER_BITS = 7,
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 16,
    parameter int DEPTH         = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    input  logic [1:0]                   in_kind,
    input  logic [REGISTER_BITS-1:0]     in_dest,
    input  logic [BITS-1:0]              in_data,
    input  logic [1:0]                   in_byte_sel,
    output logic                         in_ready,
    input  logic                         mem_valid,
    input  logic [BITS-1:0]              mem_data,
    input  logic                         irq_link_valid,
    input  logic [ADDRESS_BITS-1:0]      irq_link_addr,
    output logic                         reg_wr_en,
    output logic [REGISTER_BITS-1:0]     reg_wr_sel,
    output logic [BITS-1:0]              reg_out,
    output logic [$clog2(DEPTH+1)-1:0]   pending_count,
    output logic                         err_underflow
`ifdef SLURM16_WB_SCOREBOARD_EN
    ,
    input  logic [REGISTER_BITS-1:0]     query_sel,
    output logic                         query_pending
`endif
);

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DEPTH-1:0]         dest_match_vec;
    logic [REGISTER_BITS-1:0] head_dest;
    wb_kind_t                 head_kind;
    logic [1:0]               head_byte_sel;

    logic is_load;
    logic load_pending_data;
    logic retire;
    logic port_free;
    logic load_push;
    logic direct_accept;

    logic [7:0]      sel_byte;
    logic [BITS-1:0] load_value;
    logic [BITS-1:0] irq_value;

    assign is_load           = (in_kind != 2'(KIND_DIRECT));
    assign load_pending_data = mem_valid && !fifo_empty;
    // An IRQ write holds off the retire; memory keeps mem_valid up until it lands.
    assign retire            = !RST && load_pending_data && !irq_link_valid;
    assign port_free         = !irq_link_valid && !load_pending_data;

    assign in_ready = in_valid && !RST &&
                      (is_load ? !fifo_full : (port_free && !(|dest_match_vec)));

    assign load_push     = in_ready && is_load;
    assign direct_accept = in_ready && !is_load;

    // An invalid byte select leaves sel_byte at zero, which yields 0 for both byte kinds.
    always_comb begin
        sel_byte = 8'h00;
        if (head_byte_sel == BYTE_SEL_UPPER) begin
            sel_byte = mem_data[15:8];
        end else if (head_byte_sel == BYTE_SEL_LOWER) begin
            sel_byte = mem_data[7:0];
        end
        load_value = '0;
        case (head_kind)
            KIND_LOAD_WORD:    load_value = mem_data;
            KIND_LOAD_BYTE_ZX: load_value = BITS'(sel_byte);
            KIND_LOAD_BYTE_SX: load_value = {{(BITS-8){sel_byte[7]}}, sel_byte};
            default:           load_value = '0;
        endcase
    end

    if (ADDRESS_BITS >= BITS) begin : g_link_trunc
        assign irq_value = irq_link_addr[BITS-1:0];
    end else begin : g_link_ext
        assign irq_value = {{(BITS-ADDRESS_BITS){1'b0}}, irq_link_addr};
    end

    // Writes to r0 still consume the port but leave the outputs idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_wr_en  <= 1'b0;
            reg_wr_sel <= '0;
            reg_out    <= '0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_wr_sel <= '0;
            reg_out    <= '0;
            if (irq_link_valid) begin
                reg_wr_en  <= 1'b1;
                reg_wr_sel <= REGISTER_BITS'(INTERRUPT_LINK_REGISTER);
                reg_out    <= irq_value;
            end else if (retire) begin
                if (head_dest != '0) begin
                    reg_wr_en  <= 1'b1;
                    reg_wr_sel <= head_dest;
                    reg_out    <= load_value;
                end
            end else if (direct_accept) begin
                if (in_dest != '0) begin
                    reg_wr_en  <= 1'b1;
                    reg_wr_sel <= in_dest;
                    reg_out    <= in_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_underflow <= 1'b0;
        end else if (mem_valid && fifo_empty) begin
            err_underflow <= 1'b1;
        end
    end

`ifdef SLURM16_WB_SCOREBOARD_EN
    logic [DEPTH-1:0] query_vec;
    assign query_pending = (|query_vec) && (query_sel != '0);
`endif

    slurm16_cpu_wb_load_fifo #(
        .REGISTER_BITS (REGISTER_BITS),
        .DEPTH         (DEPTH)
    ) u_load_fifo (
        .clk           (CLK),
        .srst          (RST),
        .push          (load_push),
        .push_dest     (in_dest),
        .push_kind     (wb_kind_t'(in_kind)),
        .push_byte_sel (in_byte_sel),
        .pop           (retire),
        .head_dest     (head_dest),
        .head_kind     (head_kind),
        .head_byte_sel (head_byte_sel),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (pending_count),
        .match_dest    (in_dest),
        .match_vec     (dest_match_vec)
`ifdef SLURM16_WB_SCOREBOARD_EN
        ,
        .query_dest    (query_sel),
        .query_vec     (query_vec)
`endif
    );

endmodule
